// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage valid/ready pipelined bitwise logic unit.
// Stage 1 registers the incoming transaction. Stage 2 computes one of eight
// bitwise operations, registers the result, and can write it back to an
// internal accumulator. The accumulator can stand in for operand A.
// Optional build macro LOGIC_UNIT_FLAGS_EN adds the registered out_zero and
// out_parity result flags.
module logic_unit_pipe #(
    parameter int unsigned      WIDTH    = 8,
    parameter logic [WIDTH-1:0] ACC_INIT = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             acc_sel,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] acc
`ifdef LOGIC_UNIT_FLAGS_EN
    ,
    output logic             out_zero,
    output logic             out_parity
`endif
);

    // Bitwise operation selected by the 3-bit opcode
    function automatic logic [WIDTH-1:0] apply_op(
        input logic [2:0]       sel,
        input logic [WIDTH-1:0] opa,
        input logic [WIDTH-1:0] opb
    );
        logic [WIDTH-1:0] res;
        case (sel)
            3'b000:  res = opa & opb;
            3'b001:  res = opa | opb;
            3'b010:  res = ~opa;
            3'b011:  res = ~(opa & opb);
            3'b100:  res = ~(opa | opb);
            3'b101:  res = opa ^ opb;
            3'b110:  res = ~(opa ^ opb);
            3'b111:  res = opb;
            default: res = {WIDTH{1'b0}};
        endcase
        return res;
    endfunction

`ifdef LOGIC_UNIT_FLAGS_EN
    // Even parity of a result word (XOR reduction)
    function automatic logic calc_parity(input logic [WIDTH-1:0] val);
        return ^val;
    endfunction
`endif

    logic             s1_valid_r;
    logic [WIDTH-1:0] s1_a_r;
    logic [WIDTH-1:0] s1_b_r;
    logic [2:0]       s1_op_r;
    logic             s1_acc_sel_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] y_r;
    logic [WIDTH-1:0] acc_r;

    logic             in_ready_s;
    logic             s1_accept_s;
    logic             s2_load_s;
    logic [WIDTH-1:0] opa_s;
    logic [WIDTH-1:0] result_s;

    // Handshake decode and stage-2 datapath; operand A comes from the
    // accumulator when the stage-1 transaction asks for it
    always_comb begin
        in_ready_s  = !s1_valid_r || !out_valid_r || out_ready;
        s1_accept_s = in_valid && in_ready_s;
        s2_load_s   = s1_valid_r && (!out_valid_r || out_ready);
        if (s1_acc_sel_r) begin
            opa_s = acc_r;
        end else begin
            opa_s = s1_a_r;
        end
        result_s = apply_op(s1_op_r, opa_s, s1_b_r);
    end

    // Stage-1 payload capture on an accepted input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_a_r       <= {WIDTH{1'b0}};
            s1_b_r       <= {WIDTH{1'b0}};
            s1_op_r      <= 3'b000;
            s1_acc_sel_r <= 1'b0;
        end else if (s1_accept_s) begin
            s1_a_r       <= a;
            s1_b_r       <= b;
            s1_op_r      <= op;
            s1_acc_sel_r <= acc_sel;
        end
    end

    // Stage-1 occupancy: filled on accept, emptied when stage 2 takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
        end else if (s1_accept_s) begin
            s1_valid_r <= 1'b1;
        end else if (s2_load_s) begin
            s1_valid_r <= 1'b0;
        end
    end

    // Stage-2 result register; holds under backpressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            y_r         <= {WIDTH{1'b0}};
        end else if (s2_load_s) begin
            out_valid_r <= 1'b1;
            y_r         <= result_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    // Accumulator: clear has priority over a same-edge write-back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= ACC_INIT;
        end else if (acc_clr) begin
            acc_r <= ACC_INIT;
        end else if (s2_load_s && s1_acc_sel_r) begin
            acc_r <= result_s;
        end
    end

`ifdef LOGIC_UNIT_FLAGS_EN
    logic zero_r;
    logic parity_r;

    // Result flags registered alongside y so they hold with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_r   <= 1'b0;
            parity_r <= 1'b0;
        end else if (s2_load_s) begin
            zero_r   <= (result_s == {WIDTH{1'b0}});
            parity_r <= calc_parity(result_s);
        end
    end

    assign out_zero   = zero_r;
    assign out_parity = parity_r;
`endif

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign y         = y_r;
    assign acc       = acc_r;

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, pipelined successor to the team's single-bit basic-gates block.
- Applies one of eight bitwise logic operations to WIDTH-bit operands, selected per transaction.
- Uses valid/ready handshakes on input and output, with a 2-stage pipeline.
- An internal accumulator can replace operand a, so chained logic reductions can run inside the ALU datapath without external feedback.

Parameters:
- WIDTH, 8: operand and result width in bits, minimum 1.
- ACC_INIT, 0: accumulator value after reset and after acc_clr; WIDTH bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input transaction present
- in_ready  output  1  block can accept an input this cycle
- a  input  WIDTH  operand A, ignored when acc_sel=1
- b  input  WIDTH  operand B
- op  input  3  operation select
- acc_sel  input  1  use accumulator as operand A; write result back to accumulator
- acc_clr  input  1  synchronous accumulator clear to ACC_INIT
- out_valid  output  1  result present
- out_ready  input  1  downstream accepts result
- y  output  WIDTH  result
- acc  output  WIDTH  current accumulator value

Behaviour:
- Single clock domain: clk. rst_n is asynchronous and active-low.
- Op encoding:
  - 000 AND
  - 001 OR
  - 010 NOT A
  - 011 NAND
  - 100 NOR
  - 101 XOR
  - 110 XNOR
  - 111 PASS B (loads b, e.g. to preload the accumulator)
- All operations are bitwise. No carries, no width growth.
- Reset (rst_n=0, takes effect immediately):
  - s1_valid=0, out_valid=0, y=0, acc=ACC_INIT.
  - in_ready=1 once rst_n is high.
- Stage 1 (input register):
  - Captures a, b, op, acc_sel when in_valid && in_ready.
  - Sets s1_valid.
- Stage 2 (compute and output register):
  - Loads when s1_valid && (!out_valid || out_ready).
  - y = f(op, A, b), where A = acc if the stage-1 acc_sel=1, else the stage-1 a.
  - out_valid is set on load.
  - If acc_sel=1, acc <= y on the same edge.
- Ordering: stage-2 loads happen in transaction order, so back-to-back acc_sel transactions always see the previous result. No hazard, no bubble.
- Output clear: out_valid clears when out_ready && out_valid && stage 2 is not reloaded on the same edge.
- in_ready = !s1_valid || (!out_valid || out_ready). It is combinational, with no dependency on in_valid.
- Latency: accept edge N gives out_valid=1 after edge N+1, i.e. 2 cycles. Throughput is 1 transaction per cycle with out_ready=1.
- Backpressure (out_ready=0):
  - y, out_valid and stage 1 hold their values.
  - in_ready drops once stage 1 is full.
  - Data is never dropped or duplicated.
- y is stable while out_valid=1 && out_ready=0.
- acc_clr:
  - acc <= ACC_INIT at the next edge, independent of the handshake.
  - If a stage-2 load with acc_sel=1 occurs on the same edge, y uses the pre-clear acc, and the clear wins: acc=ACC_INIT.
  - Transactions still in stage 1 see the cleared value.
- Reset mid-operation: all in-flight transactions are discarded with no output. Accumulator returns to ACC_INIT.
- acc_sel=1 with op=010 (NOT A) inverts the accumulator in place.

Optional Feature:
- Macro: LOGIC_UNIT_FLAGS_EN.
- When defined, adds two outputs, both registered with y and held under backpressure. Both reset to 0.
  - out_zero (1 bit): y == 0.
  - out_parity (1 bit): XOR-reduction of y.
- When undefined, these ports and their logic do not exist. All other behaviour is identical.

Test Plan:
- Basic ops: WIDTH=8, a=8'hC3, b=8'hA5, out_ready=1, op 0..7 back-to-back. Required y, in order, each 2 cycles after its accept, one per cycle: 81, E7, 3C, 7E, 18, 66, 99, A5.
- Accumulate chain: ACC_INIT=0.
  - PASS b=8'h0F with acc_sel=1 -> acc=0F.
  - Then XOR b=8'hFF with acc_sel=1 -> y=F0, acc=F0.
  - Then AND b=8'h3C with acc_sel=1 -> y=30, acc=30.
  - All three are issued on consecutive cycles.
- Backpressure: issue 4 transactions with out_ready=0.
  - in_ready=0 after 2 accepts; y holds the first result.
  - Release out_ready: all 4 results arrive in order, none lost or duplicated.
- Clear collision: acc=F0, with acc_clr=1 on the same edge as a stage-2 load of OR b=8'h01 acc_sel=1 -> y=F1, acc=00.
- Reset mid-flight: assert rst_n=0 with 2 transactions in flight and acc=55.
  - out_valid=0 and acc=ACC_INIT immediately, with no clock edge needed.
  - No stale output after release.
- Flags (LOGIC_UNIT_FLAGS_EN): AND a=8'hF0 b=8'h0F -> out_zero=1, out_parity=0; XOR a=8'h01 b=8'h00 -> out_zero=0, out_parity=1.
